// File: rtl/countdown_pkg.sv
// Shared types and helpers for the BCD countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Clamp a nibble to a legal BCD digit; 0xA..0xF become 9.
    function automatic logic [3:0] bcd_sat(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/countdown_timer_digit.sv
// One BCD digit of the down-counter: loadable, decrements with wrap 0 -> 9.
module bcd_down_digit
    import countdown_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] q,
    output logic       zero
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    // Next digit value: load wins, otherwise borrow-driven decrement.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = bcd_sat(load_val);
        end else if (dec) begin
            q_d = (q_q == 4'd0) ? BCD_MAX : (q_q - 4'd1);
        end
    end

    // Digit register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign zero = (q_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// Multi-digit BCD countdown timer with prescaler, run/pause and expiry flag.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | loaded or reset, waiting for start
//   RUN    | prescaler running, count decrements once per TICK_DIV cycles
//   PAUSED | prescaler and count frozen, start resumes
//   DONE   | count reached zero, expired held until load or start
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  pause,
    output logic [4*DIGITS-1:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  expired
);

    // A divide-by-one prescaler still needs a one-bit register to stay legal.
    localparam int              PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PS_LAST = PW'(TICK_DIV - 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            expired_q, expired_d;

    logic [DIGITS-1:0] zero;
    logic [DIGITS-1:0] dec;
    logic              tick;
    logic              count_zero;
    logic              upper_zero;
    logic              count_is_one;

    // Pause and load both suppress the tick in the cycle they are seen.
    assign tick = (state_q == RUN) && !load && !pause && (presc_q == PS_LAST);

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        if (gi == 0) begin : g_lsd
            assign dec[gi] = tick;
        end else begin : g_upper
            assign dec[gi] = tick & (&zero[gi-1:0]);
        end

        bcd_down_digit u_digit (
            .clk      (clk),
            .rst      (rst),
            .load     (load),
            .load_val (load_value[4*gi +: 4]),
            .dec      (dec[gi]),
            .q        (count[4*gi +: 4]),
            .zero     (zero[gi])
        );
    end

    if (DIGITS > 1) begin : g_upper_zero
        assign upper_zero = &zero[DIGITS-1:1];
    end else begin : g_single
        assign upper_zero = 1'b1;
    end

    assign count_zero   = &zero;
    // The value 1 is the only one whose next tick lands on zero.
    assign count_is_one = upper_zero && (count[3:0] == 4'd1);

    // Next state, prescaler and registered output values.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        if (count_zero) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                            presc_d = '0;
                        end
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (tick) begin
                        presc_d = '0;
                        if (count_is_one) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSED: begin
                    if (start && !pause) begin
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d    = (state_d == RUN) || (state_d == PAUSED);
        expired_d = (state_d == DONE);
    end

    // FSM state, prescaler and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (TICK_DIV 4 and 1) share stimulus,
// each checked against an integer-valued reference model via a scoreboard.
module tb_countdown_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ld, st, pz;
    logic [15:0] lv;
    logic [15:0] c0, c1;
    logic        b0, b1, d0, d1, x0, x1;

    countdown_timer #(.DIGITS(4), .TICK_DIV(4)) dut0 (
        .clk(clk), .rst(rst), .load(ld), .load_value(lv), .start(st), .pause(pz),
        .count(c0), .busy(b0), .done(d0), .expired(x0)
    );

    countdown_timer #(.DIGITS(4), .TICK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .load(ld), .load_value(lv), .start(st), .pause(pz),
        .count(c1), .busy(b1), .done(d1), .expired(x1)
    );

    typedef struct packed {
        logic [15:0] c;
        logic        b;
        logic        d;
        logic        e;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1;

    int total = 0;
    int bad   = 0;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
    int m_mode[2];
    int m_ps[2];
    int m_n[2];

    function automatic int td(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int bcd_to_int(input logic [15:0] v);
        int r = 0;
        int w = 1;
        for (int k = 0; k < 4; k++) begin
            int dg = int'(v[4*k +: 4]);
            if (dg > 9) dg = 9;
            r += dg * w;
            w *= 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] int_to_bcd(input int n);
        logic [15:0] r;
        int t = n;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic model_step(input int i, input bit l, input logic [15:0] v,
                              input bit s, input bit p, output exp_t e);
        bit dn = 1'b0;
        if (l) begin
            m_n[i]    = bcd_to_int(v);
            m_ps[i]   = 0;
            m_mode[i] = M_IDLE;
        end else begin
            case (m_mode[i])
                M_IDLE, M_DONE: begin
                    if (s) begin
                        if (m_n[i] == 0) begin
                            m_mode[i] = M_DONE;
                            dn = 1'b1;
                        end else begin
                            m_mode[i] = M_RUN;
                            m_ps[i]   = 0;
                        end
                    end
                end
                M_RUN: begin
                    if (p) begin
                        m_mode[i] = M_PAUSED;
                    end else if (m_ps[i] == td(i) - 1) begin
                        m_ps[i] = 0;
                        m_n[i]  = m_n[i] - 1;
                        if (m_n[i] == 0) begin
                            m_mode[i] = M_DONE;
                            dn = 1'b1;
                        end
                    end else begin
                        m_ps[i] = m_ps[i] + 1;
                    end
                end
                M_PAUSED: if (s && !p) m_mode[i] = M_RUN;
                default: ;
            endcase
        end
        e.c = int_to_bcd(m_n[i]);
        e.b = (m_mode[i] == M_RUN) || (m_mode[i] == M_PAUSED);
        e.d = dn;
        e.e = (m_mode[i] == M_DONE);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_IDLE;
            m_ps[i]   = 0;
            m_n[i]    = 0;
        end
    endtask

    // One cycle of stimulus; the expectation for the following edge is queued.
    task automatic drive(input bit l, input logic [15:0] v, input bit s, input bit p);
        exp_t e;
        @(negedge clk);
        #1;
        ld = l; lv = v; st = s; pz = p;
        model_step(0, l, v, s, p, e);
        q0.push_back(e);
        model_step(1, l, v, s, p, e);
        q1.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // Scoreboard monitor: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            m0 = q0.pop_front();
            total++;
            if ({c0, b0, d0, x0} !== m0) begin
                bad++;
                $display("FAIL sb_td4 t=%0t actual count=%h busy=%b done=%b expired=%b required count=%h busy=%b done=%b expired=%b",
                         $time, c0, b0, d0, x0, m0.c, m0.b, m0.d, m0.e);
            end
        end
        if (q1.size() > 0) begin
            m1 = q1.pop_front();
            total++;
            if ({c1, b1, d1, x1} !== m1) begin
                bad++;
                $display("FAIL sb_td1 t=%0t actual count=%h busy=%b done=%b expired=%b required count=%h busy=%b done=%b expired=%b",
                         $time, c1, b1, d1, x1, m1.c, m1.b, m1.d, m1.e);
            end
        end
    end

    // Idle until both instances pulse done; reports the edge index of each pulse.
    task automatic run_until_done(input int base, input int maxc,
                                  input int want0, input int want1, input string nm);
        int f0 = -1;
        int f1 = -1;
        for (int k = 1; k <= maxc && (f0 < 0 || f1 < 0); k++) begin
            drive(1'b0, 16'h0, 1'b0, 1'b0);
            if (f0 < 0 && d0) f0 = base + k - 1;
            if (f1 < 0 && d1) f1 = base + k - 1;
        end
        chk({nm, "_done_edge_td4"}, f0, want0);
        chk({nm, "_done_edge_td1"}, f1, want1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b0; ld = 1'b0; st = 1'b0; pz = 1'b0; lv = 16'h0;
        model_reset();
        #2;
        chk("por_count", int'(c0), 0);
        chk("por_flags", int'({b0, d0, x0}), 0);
        #10 rst = 1'b1;

        // Basic countdown from 12 with TICK_DIV=4.
        drive(1'b1, 16'h0012, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        idle(1);
        chk("start_busy", int'(b0), 1);
        idle(3);
        chk("before_tick", int'(c0), 16'h0012);
        idle(1);
        chk("first_tick", int'(c0), 16'h0011);
        run_until_done(5, 80, 48, 12, "basic");
        idle(3);
        chk("expired_hold", int'(x0), 1);
        chk("done_single", int'(d0), 0);
        chk("count_zero_hold", int'(c0), 0);

        // Borrow chain across three digits.
        drive(1'b1, 16'h1000, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        idle(1);
        chk("borrow_hold", int'(c1), 16'h1000);
        idle(1);
        chk("borrow_0999", int'(c1), 16'h0999);
        idle(1);
        chk("borrow_0998", int'(c1), 16'h0998);
        run_until_done(3, 4100, 4000, 1000, "borrow");

        // Pause at prescaler=2 for ten cycles, then resume.
        drive(1'b1, 16'h0012, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        idle(2);
        for (int k = 0; k < 10; k++) drive(1'b0, 16'h0, 1'b0, 1'b1);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        chk("pause_frozen", int'(c0), 16'h0012);
        chk("pause_busy", int'(b0), 1);
        run_until_done(13, 80, 59, 23, "pause");

        // Saturating load during RUN, then zero load and start.
        drive(1'b1, 16'h0012, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        idle(3);
        drive(1'b1, 16'h0A5F, 1'b0, 1'b0);
        idle(1);
        chk("sat_count", int'(c0), 16'h0959);
        chk("sat_busy", int'(b0), 0);
        drive(1'b1, 16'h0000, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        idle(1);
        chk("zero_start_done", int'({d0, x0}), 2'b11);
        idle(1);
        chk("zero_start_pulse", int'({d0, x0}), 2'b01);

        // Simultaneous controls.
        drive(1'b1, 16'h0034, 1'b1, 1'b0);
        idle(1);
        chk("load_start_idle", int'(b0), 0);
        chk("load_start_val", int'(c0), 16'h0034);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        idle(1);
        drive(1'b0, 16'h0, 1'b1, 1'b1);
        idle(5);
        chk("start_pause_frz", int'(c0), 16'h0034);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        idle(6);

        // Randomized control traffic.
        for (int k = 0; k < 600; k++) begin
            logic [15:0] v;
            bit l, s, p;
            l = ($urandom_range(0, 19) == 0);
            s = ($urandom_range(0, 5) == 0);
            p = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) v = 16'($urandom);
            else v = 16'($urandom_range(0, 40));
            drive(l, v, s, p);
        end

        // Asynchronous reset while running, between clock edges.
        drive(1'b1, 16'h0099, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        idle(5);
        @(negedge clk);
        #2;
        ld = 1'b0; st = 1'b0; pz = 1'b0; lv = 16'h0;
        rst = 1'b0;
        #1;
        chk("rst_count_td4", int'(c0), 0);
        chk("rst_flags_td4", int'({b0, d0, x0}), 0);
        chk("rst_count_td1", int'(c1), 0);
        chk("rst_flags_td1", int'({b1, d1, x1}), 0);
        model_reset();
        #1 rst = 1'b1;
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        idle(1);
        chk("rst_then_start", int'({d0, x0}), 2'b11);
        idle(2);

        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable multi-digit BCD down-counter with a cycle prescaler, run/pause control and an expiry flag. It runs in the opposite direction to the team's limit-wrapping up-counter: it counts a preset value down to zero, propagating borrows between digits instead of carries. It drives seven-segment countdown displays and timeout logic on the DE0-CV board.

## Interface
- `DIGITS`, 4: number of BCD digits; legal range 1–8.
- `TICK_DIV`, 50_000_000: clock cycles per decrement; minimum 1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset; clears all state immediately.
- `load` in 1: loads `load_value`; highest-priority control.
- `load_value` in 4*DIGITS: BCD preset; digit 0 in bits [3:0].
- `start` in 1: begin the countdown, or resume from pause.
- `pause` in 1: freeze the countdown.
- `count` out 4*DIGITS: current BCD value.
- `busy` out 1: high in RUN or PAUSED.
- `done` out 1: one-cycle pulse when the count reaches zero.
- `expired` out 1: level, high while in DONE.

## Operation
- States: IDLE, RUN, PAUSED, DONE. Reset state is IDLE.
- Reset values: `count`=0, prescaler=0, `busy`=0, `done`=0, `expired`=0.
- `load` in any state:
  - `count` ← `load_value`; any digit >9 is saturated to 9.
  - Prescaler ← 0; state → IDLE.
  - `start` and `pause` are ignored that cycle.
- `start` in IDLE or DONE:
  - `count`≠0: state → RUN, prescaler ← 0.
  - `count`=0: state → DONE, `done` pulses.
- RUN:
  - Prescaler counts 0..TICK_DIV-1.
  - A tick occurs in the cycle where prescaler = TICK_DIV-1; the prescaler wraps to 0.
- On a tick:
  - Digit 0 decrements.
  - Digit i decrements only if all lower digits are 0 (ripple borrow); a digit at 0 that decrements wraps to 9.
  - If the post-tick value is 0: state → DONE and `done`=1 for exactly one cycle.
- `pause` in RUN: state → PAUSED; prescaler and `count` hold. `pause` has priority over `start` in RUN.
- PAUSED:
  - `start` with `pause` low → RUN; prescaler resumes from its held value.
  - `start` with `pause` high is ignored.
- DONE: `expired`=1 and `count`=0, held until `load` or `start`.
- `start` in RUN and `pause` outside RUN are no-ops.

## Timing
- All outputs are registered.
- `start` sampled at edge k → `busy`=1 from k.
- The first decrement is visible exactly TICK_DIV edges after entering RUN.
- A countdown from N (binary-equivalent value) takes N·TICK_DIV RUN cycles.
- `done` rises on the same edge where `count` becomes 0 and `expired` rises.
- TICK_DIV=1: one decrement per RUN cycle, with no gaps.
- `load` takes effect on the next edge; `count` shows the new value after that edge.
- Reset assertion clears outputs asynchronously. Deassertion is synchronized externally.

## Structure
- Package `countdown_pkg`:
  - `state_t` enum (IDLE, RUN, PAUSED, DONE).
  - `BCD_MAX`=4'd9.
  - `bcd_sat()` function for load saturation.
- Sub-module `bcd_down_digit`:
  - Inputs: `clk`, `rst`, `load`, `load_val[3:0]`, `dec`.
  - Outputs: `q[3:0]` and combinational `zero`.
  - Instantiated DIGITS times in a generate loop; `dec[i]` = tick & AND of `zero[0..i-1]`.
- Top level holds the FSM, the prescaler (width $clog2(TICK_DIV)), the terminal-zero detect and the output registers.

## Test plan
- Reset: drive `rst`=0 mid-simulation without a clock edge → `count`=0x0000, `busy`=0, `done`=0, `expired`=0 immediately.
- Basic countdown (DIGITS=4, TICK_DIV=4):
  - Stimulus: load 0x0012, then start.
  - `count` reads 0x0011 after 4 cycles.
  - `done` pulses once at RUN cycle 48 with `count`=0x0000; `expired` stays 1.
- Borrow chain (TICK_DIV=1):
  - Stimulus: load 0x1000, then start.
  - Successive values 0x0999, 0x0998.
  - After 1000 cycles: `done`=1.
- Pause/resume (TICK_DIV=4):
  - Stimulus: pause for 10 cycles at prescaler=2.
  - `count` and prescaler are frozen throughout.
  - After start, the next tick comes 2 cycles later; total RUN cycles are unchanged.
- Load/saturation:
  - Load 0x0A5F during RUN → `count`=0x0959, IDLE, `busy`=0.
  - Load 0x0000 then start → DONE next edge with one-cycle `done`.
- Simultaneous controls: `load`+`start` in one cycle → IDLE with the loaded value. `start`+`pause` in RUN → PAUSED.
